keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clk cycles per column slot; legal values are 4 or greater.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 8, consecutive agreeing samples needed to accept a press or release; legal values are 2 to 255.
REQ-003 SHALL have port clk, input, 1 bit, rising-edge system clock.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port row_n, input, 4 bits, keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col_n, output, 4 bits, column drive, active-low, one-cold.
REQ-007 SHALL have port btn_valid, output, 1 bit, one-cycle pulse when a debounced key press is accepted.
REQ-008 SHALL have port btn_char, output, 8 bits, ASCII code of the accepted key, held until the next press.
REQ-009 SHALL have port key_held, output, 1 bit, high from the accept cycle until the release is accepted.

Function
REQ-010 SHALL pass row_n through a 2-flop synchronizer; all row decisions use only the synchronized value.
REQ-011 SHALL run a slot counter from 0 to SCAN_DIV-1 and wrap; the sample point is the cycle where the counter equals SCAN_DIV-1.
REQ-012 SHALL map keys by (row, column), row 0 first: row0 = '1','2','3','+'; row1 = '4','5','6','-'; row2 = '7','8','9','*'; row3 = 'C','0',8'h08,'='.
REQ-013 SHALL implement the FSM states SCAN, PRESS_DB, HELD and REL_DB.
REQ-014 SCAN: at each sample with no row low, SHALL rotate col_n to the next column (c0, c1, c2, c3, c0, ...).
REQ-015 SCAN: at a sample with at least one row low, SHALL latch the lowest-index low row and the current column, set debounce count to 1, freeze col_n, and go to PRESS_DB.
REQ-016 PRESS_DB: at each sample, if the latched row is low, SHALL increment the count; if the count reaches DEBOUNCE_CNT, SHALL go to HELD.
REQ-017 PRESS_DB: at a sample with the latched row high, SHALL clear the count, emit no btn_valid, advance col_n, and return to SCAN.
REQ-018 On the PRESS_DB-to-HELD transition edge, SHALL register btn_char, pulse btn_valid for exactly 1 cycle, and set key_held.
REQ-019 Press latency SHALL be at most 1 clk after the DEBOUNCE_CNT-th qualifying sample.
REQ-020 HELD: col_n SHALL stay frozen; at a sample with the latched row high, SHALL set count to 1 and go to REL_DB.
REQ-021 REL_DB: at a sample with the latched row high, SHALL increment the count; at DEBOUNCE_CNT, SHALL clear key_held, advance col_n, and go to SCAN.
REQ-022 REL_DB: at a sample with the latched row low (bounce), SHALL return to HELD with no new btn_valid.
REQ-023 SHALL have no auto-repeat: one physical press yields exactly one btn_valid.
REQ-024 While a key is held, SHALL ignore presses on other rows and other columns; a second key is only seen after the first is released and scanned.
REQ-025 With several rows low in one column at one sample, SHALL accept only the lowest-index row.
REQ-026 btn_valid SHALL never be high on 2 consecutive cycles.
REQ-027 The debounce count width SHALL hold DEBOUNCE_CNT without wrapping.

Reset
REQ-028 On rst_n low, SHALL immediately set col_n=4'b1110, btn_valid=0, btn_char=8'h00, key_held=0, FSM=SCAN, slot counter=0, debounce count=0, and synchronizer flops to 4'b1111.
REQ-029 A reset asserted mid-press SHALL abort it with no btn_valid; after release, scanning SHALL restart at column 0.

Verification (bench params SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-030 SHALL test idle: row_n=4'hF for 64 clocks -> col_n cycles 1110, 1101, 1011, 0111 every 4 clocks; btn_valid stays 0.
REQ-031 SHALL test a clean press: key (row1, col2) held for 40 clocks -> exactly one btn_valid pulse, btn_char=8'h36 ('6'), within 1 clk after the 3rd qualifying sample; key_held=1 until 3 high samples after release.
REQ-032 SHALL test a bounce: (row3, col1) low for 1 sample, then high, then low for 5 samples -> exactly one btn_valid, btn_char=8'h30.
REQ-033 SHALL test two keys: (row0, col3) and (row2, col3) pressed together -> btn_char=8'h2B ('+') only; then (row3, col2) after release -> btn_char=8'h08.
REQ-034 SHALL test release bounce: during REL_DB, row goes low for 1 sample -> returns to HELD; no second pulse; key_held stays 1.
REQ-035 SHALL test reset mid-press: rst_n pulsed during PRESS_DB -> all outputs at reset values at once; no btn_valid.

Source files
------------

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and ASCII decode
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       btn_valid,
  output logic [7:0] btn_char,
  output logic       key_held
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_e;

  state_e        state_q, state_d;
  logic [3:0]    row_s1_q, row_s2_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [1:0]    first_row;
  logic          btn_valid_q, btn_valid_d;
  logic [7:0]    btn_char_q, btn_char_d;
  logic          key_held_q, key_held_d;
  logic          sample, any_low, lat_low, cnt_done;

  function automatic logic [7:0] key_char(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_char = "1";
      4'h1: key_char = "2";
      4'h2: key_char = "3";
      4'h3: key_char = "+";
      4'h4: key_char = "4";
      4'h5: key_char = "5";
      4'h6: key_char = "6";
      4'h7: key_char = "-";
      4'h8: key_char = "7";
      4'h9: key_char = "8";
      4'hA: key_char = "9";
      4'hB: key_char = "*";
      4'hC: key_char = "C";
      4'hD: key_char = "0";
      4'hE: key_char = 8'h08;
      default: key_char = "=";
    endcase
  endfunction

  // Rows are asynchronous to clk; nothing downstream looks at row_n directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q <= 4'b1111;
      row_s2_q <= 4'b1111;
    end else begin
      row_s1_q <= row_n;
      row_s2_q <= row_s1_q;
    end
  end

  assign sample   = (slot_q == SW'(SCAN_DIV - 1));
  assign slot_d   = sample ? '0 : slot_q + 1'b1;
  assign any_low  = |(~row_s2_q);
  assign lat_low  = ~row_s2_q[row_idx_q];
  assign cnt_inc  = cnt_q + 1'b1;
  assign cnt_done = (cnt_inc == CW'(DEBOUNCE_CNT));

  always_comb begin
    first_row = 2'd3;
    if (!row_s2_q[0])      first_row = 2'd0;
    else if (!row_s2_q[1]) first_row = 2'd1;
    else if (!row_s2_q[2]) first_row = 2'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SCAN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sample) begin
      case (state_q)
        SCAN:     if (any_low) state_d = PRESS_DB;
        PRESS_DB: if (!lat_low) state_d = SCAN;
                  else if (cnt_done) state_d = HELD;
        HELD:     if (!lat_low) state_d = REL_DB;
        REL_DB:   if (lat_low) state_d = HELD;
                  else if (cnt_done) state_d = SCAN;
        default:  state_d = SCAN;
      endcase
    end
  end

  // The column index stays frozen from latch until release, so it doubles as the latched column.
  always_comb begin
    cnt_d       = cnt_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    btn_valid_d = 1'b0;
    btn_char_d  = btn_char_q;
    key_held_d  = key_held_q;
    if (sample) begin
      case (state_q)
        SCAN: begin
          if (any_low) begin
            row_idx_d = first_row;
            cnt_d     = CW'(1);
          end else begin
            col_idx_d = col_idx_q + 1'b1;
          end
        end
        PRESS_DB: begin
          if (!lat_low) begin
            cnt_d     = '0;
            col_idx_d = col_idx_q + 1'b1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_done) begin
              btn_valid_d = 1'b1;
              btn_char_d  = key_char(row_idx_q, col_idx_q);
              key_held_d  = 1'b1;
            end
          end
        end
        HELD: begin
          if (!lat_low) cnt_d = CW'(1);
        end
        REL_DB: begin
          if (lat_low) begin
            cnt_d = '0;
          end else if (cnt_done) begin
            cnt_d      = '0;
            key_held_d = 1'b0;
            col_idx_d  = col_idx_q + 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      cnt_q       <= '0;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      btn_valid_q <= 1'b0;
      btn_char_q  <= 8'h00;
      key_held_q  <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      btn_valid_q <= btn_valid_d;
      btn_char_q  <= btn_char_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_n     = ~(4'b0001 << col_idx_q);
  assign btn_valid = btn_valid_q;
  assign btn_char  = btn_char_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a keypad matrix model
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        btn_valid;
  logic [7:0]  btn_char;
  logic        key_held;
  logic [15:0] pressed;
  int          pe;
  int          n_vec;
  int          n_err;
  logic        prev_valid;
  logic [7:0]  exp_q[$];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .btn_valid (btn_valid),
    .btn_char  (btn_char),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key (r,c) is pressed[r*4+c]; a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (|(pressed[r*4 +: 4] & ~col_n)) row_n[r] = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pe <= 0;
    else        pe <= pe + 1;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (btn_valid) begin
      n_vec++;
      if (prev_valid) begin
        n_err++;
        $display("FAIL valid_twice: btn_valid high on consecutive cycles at %0t", $time);
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: got char %h expected no pulse at %0t", btn_char, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (btn_char !== e) begin
          n_err++;
          $display("FAIL btn_char: got %h expected %h at %0t", btn_char, e, $time);
        end
      end
    end
    prev_valid = btn_valid;
  end

  task automatic after_sample();
    do @(negedge clk); while (pe % 4 != 0);
  endtask

  task automatic wait_col(input logic [3:0] target);
    int k = 0;
    while (col_n !== target && k < 8) begin
      after_sample();
      k++;
    end
    check("wait_col", {4'h0, col_n}, {4'h0, target});
  endtask

  task automatic wait_held(input logic val, input int budget, input string name);
    int k = 0;
    while (key_held !== val && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {7'd0, key_held}, {7'd0, val});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    prev_valid = 1'b0;
    pressed = '0;
    rst_n = 1'b0;
    #12;
    check("rst_col", {4'h0, col_n}, 8'h0E);
    check("rst_valid", {7'd0, btn_valid}, 8'h00);
    check("rst_char", btn_char, 8'h00);
    check("rst_held", {7'd0, key_held}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // idle rotation
    for (int i = 0; i < 64; i++) begin
      logic [3:0] e;
      e = ~(4'b0001 << ((i / 4) % 4));
      check("idle_col", {4'h0, col_n}, {4'h0, e});
      @(negedge clk);
    end

    // clean press of '6'
    exp_q.push_back(8'h36);
    pressed[1*4+2] = 1'b1;
    wait_col(4'b1011);
    after_sample();
    after_sample();
    check("lat_valid_early", {7'd0, btn_valid}, 8'h00);
    check("lat_held_early", {7'd0, key_held}, 8'h00);
    after_sample();
    check("lat_valid", {7'd0, btn_valid}, 8'h01);
    check("lat_char", btn_char, 8'h36);
    check("lat_held", {7'd0, key_held}, 8'h01);
    repeat (40) @(negedge clk);
    after_sample();
    pressed = '0;
    after_sample();
    after_sample();
    check("rel_held_2", {7'd0, key_held}, 8'h01);
    after_sample();
    check("rel_held_3", {7'd0, key_held}, 8'h00);
    check("rel_col_adv", {4'h0, col_n}, 8'h07);

    // press bounce on '0'
    exp_q.push_back(8'h30);
    pressed[3*4+1] = 1'b1;
    wait_col(4'b1101);
    after_sample();
    pressed = '0;
    after_sample();
    check("bounce_col_adv", {4'h0, col_n}, 8'h0B);
    pressed[3*4+1] = 1'b1;
    wait_held(1'b1, 200, "bounce_accept");
    check("bounce_char", btn_char, 8'h30);
    pressed = '0;
    wait_held(1'b0, 100, "bounce_release");

    // two keys in one column, then a foreign key while held
    exp_q.push_back(8'h2B);
    pressed[0*4+3] = 1'b1;
    pressed[2*4+3] = 1'b1;
    wait_held(1'b1, 200, "two_accept");
    check("two_char", btn_char, 8'h2B);
    pressed[1*4+0] = 1'b1;
    repeat (30) @(negedge clk);
    check("two_ignore", btn_char, 8'h2B);
    pressed = '0;
    wait_held(1'b0, 100, "two_release");
    exp_q.push_back(8'h08);
    pressed[3*4+2] = 1'b1;
    wait_held(1'b1, 200, "bs_accept");
    check("bs_char", btn_char, 8'h08);
    pressed = '0;
    wait_held(1'b0, 100, "bs_release");

    // release bounce on '5'
    exp_q.push_back(8'h35);
    pressed[1*4+1] = 1'b1;
    wait_held(1'b1, 200, "rb_accept");
    pressed = '0;
    after_sample();
    pressed[1*4+1] = 1'b1;
    after_sample();
    check("rb_back_held", {7'd0, key_held}, 8'h01);
    pressed = '0;
    after_sample();
    after_sample();
    check("rb_held_2", {7'd0, key_held}, 8'h01);
    after_sample();
    check("rb_held_3", {7'd0, key_held}, 8'h00);

    // reset in the middle of debouncing '9'
    pressed[2*4+2] = 1'b1;
    wait_col(4'b1011);
    after_sample();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_col", {4'h0, col_n}, 8'h0E);
    check("mid_rst_valid", {7'd0, btn_valid}, 8'h00);
    check("mid_rst_char", btn_char, 8'h00);
    check("mid_rst_held", {7'd0, key_held}, 8'h00);
    pressed = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_col0", {4'h0, col_n}, 8'h0E);
    repeat (4) @(negedge clk);
    check("post_rst_col1", {4'h0, col_n}, 8'h0D);
    repeat (40) @(negedge clk);
    check("queue_empty", 8'(exp_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
